stepdir_ramp_ctrl: RTL

//  Acceleration-limited velocity sequencer between the SPI frame decode and one stepdir generator.

---
 rtl/rio_motion_pkg.sv | 40 ++++
 rtl/rio_tick_div.sv | 37 +++
 rtl/stepdir_ramp_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rio_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module : rio_motion_pkg
// Brief  : Shared motion types: velocity word, ramp state encoding, step rule.
// Rev    : 1.0  initial release
// ============================================================================
package rio_motion_pkg;

    localparam int STATE_W = 2;

    typedef logic signed [31:0] velocity_t;

    typedef enum logic [STATE_W-1:0] {
        DISABLED = 2'd0,
        RAMP     = 2'd1,
        HOLD     = 2'd2,
        STOPPING = 2'd3
    } ramp_state_e;

    // Moves cur toward tgt by at most accel; 34-bit math keeps the difference exact.
    function automatic velocity_t ramp_step(input velocity_t   cur,
                                            input velocity_t   tgt,
                                            input logic [31:0] accel);
        logic signed [33:0] w_diff;
        logic signed [33:0] w_acc;
        logic signed [33:0] w_next;
        w_diff = 34'(tgt) - 34'(cur);
        w_acc  = $signed({2'b00, accel});
        if ((w_diff <= w_acc) && (w_diff >= -w_acc)) begin
            w_next = 34'(tgt);
        end else if (w_diff > 0) begin
            w_next = 34'(cur) + w_acc;
        end else begin
            w_next = 34'(cur) - w_acc;
        end
        return w_next[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rio_tick_div.sv
`default_nettype none
// ============================================================================
// Module : rio_tick_div
// Brief  : Free-running divider; tick is high for one cycle every TICK_DIV.
// Rev    : 1.0  initial release
// ============================================================================
module rio_tick_div #(
    parameter int TICK_DIV = 2981
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               w_tick;

    always_comb begin
        w_tick  = (r_cnt_q == c_CNT_W'(TICK_DIV - 1));
        w_cnt_d = w_tick ? '0 : r_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/stepdir_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : stepdir_ramp_ctrl
// Brief  : Acceleration-limited velocity sequencer feeding one stepdir axis.
//          Optional soft position limits: define STEPDIR_RAMP_SOFTLIMIT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module stepdir_ramp_ctrl
    import rio_motion_pkg::*;
#(
    parameter int          TICK_DIV = 2981,
    parameter logic [31:0] ACCEL    = 32'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic signed [31:0]  target_vel,
    input  logic                target_en,
    input  logic                fault,
    output logic signed [31:0]  velocity,
    output logic                enable,
    output logic                busy,
    output logic [STATE_W-1:0]  state
`ifdef STEPDIR_RAMP_SOFTLIMIT_EN
    ,
    input  logic signed [31:0]  position,
    input  logic signed [31:0]  pos_min,
    input  logic signed [31:0]  pos_max,
    output logic                limit_hit
`endif
);

    ramp_state_e r_state_q;
    ramp_state_e w_state_d;
    velocity_t   r_vel_q;
    velocity_t   w_vel_d;
    velocity_t   r_tgt_q;
    velocity_t   w_tgt_d;
    velocity_t   w_tgt_eff;
    velocity_t   w_vel_step;
    logic        r_en_l_q;
    logic        w_en_l_d;
    logic        r_enable_q;
    logic        w_enable_d;
    logic        r_limit_q;
    logic        w_limit_d;
    logic        w_tick;
    logic        w_stop;
    logic        w_clamp;

    rio_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        w_clamp = 1'b0;
`ifdef STEPDIR_RAMP_SOFTLIMIT_EN
        w_clamp = ((position >= pos_max) && (r_tgt_q > 0)) ||
                  ((position <= pos_min) && (r_tgt_q < 0));
`endif
        w_stop     = fault | ~r_en_l_q;
        w_tgt_eff  = ((r_state_q == STOPPING) || w_clamp) ? '0 : r_tgt_q;
        w_vel_step = ramp_step(r_vel_q, w_tgt_eff, ACCEL);

        w_state_d = r_state_q;
        w_vel_d   = r_vel_q;
        // A new frame only lands in the latches; the ramp sees it from the next tick.
        w_tgt_d   = sync ? target_vel : r_tgt_q;
        w_en_l_d  = sync ? target_en  : r_en_l_q;

        case (r_state_q)
            DISABLED: begin
                w_vel_d = '0;
                if (r_en_l_q && !fault) begin
                    w_state_d = RAMP;
                end
            end
            RAMP: begin
                if (w_tick) begin
                    w_vel_d = w_vel_step;
                end
                if (w_stop) begin
                    w_state_d = STOPPING;
                end else if (w_tick && (w_vel_step == w_tgt_eff)) begin
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (w_stop) begin
                    w_state_d = STOPPING;
                end else if (w_tgt_eff != r_vel_q) begin
                    w_state_d = RAMP;
                end
            end
            STOPPING: begin
                if (w_tick) begin
                    w_vel_d = w_vel_step;
                end
                // Re-enable mid-stop resumes the ramp without touching zero first.
                if (r_en_l_q && !fault && (r_vel_q != '0)) begin
                    w_state_d = RAMP;
                end else if (w_vel_d == '0) begin
                    w_state_d = DISABLED;
                end
            end
            default: begin
                w_state_d = DISABLED;
                w_vel_d   = '0;
            end
        endcase

        w_enable_d = (w_state_d != DISABLED);
        w_limit_d  = w_clamp && ((r_state_q == RAMP) || (r_state_q == HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= DISABLED;
            r_vel_q    <= '0;
            r_tgt_q    <= '0;
            r_en_l_q   <= 1'b0;
            r_enable_q <= 1'b0;
            r_limit_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_vel_q    <= w_vel_d;
            r_tgt_q    <= w_tgt_d;
            r_en_l_q   <= w_en_l_d;
            r_enable_q <= w_enable_d;
            r_limit_q  <= w_limit_d;
        end
    end

    assign velocity = r_vel_q;
    assign enable   = r_enable_q;
    assign busy     = (r_state_q != DISABLED);
    assign state    = r_state_q;

`ifdef STEPDIR_RAMP_SOFTLIMIT_EN
    assign limit_hit = r_limit_q;
`else
    logic w_limit_unused;
    assign w_limit_unused = r_limit_q;
`endif

endmodule
`default_nettype wire
